// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO_DEPTH-entry byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 frame).
module uart_tx_buffered #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SYM_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               serial_q, serial_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic               push;
  logic               pop;
  logic               sym_end;
  logic [7:0]         head;

  // Next-state: FIFO bookkeeping plus the frame serializer
  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    pop       = 1'b0;
    push      = data_in_valid && ready_q;
    head      = mem_q[rd_ptr_q];
    sym_end   = (sym_cnt_q == SYM_W'(SYMBOL_EDGE_TIME - 1));

    if (state_q != IDLE) begin
      sym_cnt_d = sym_end ? '0 : SYM_W'(sym_cnt_q + 1'b1);
    end

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          state_d   = START;
          serial_d  = 1'b0;
          shift_d   = head;
          sym_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^head;
`endif
        end
      end
      START: begin
        if (sym_end) begin
          state_d   = DATA;
          serial_d  = shift_q[0];
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (sym_end) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = parity_q;
`else
            state_d  = STOP;
            serial_d = 1'b1;
`endif
          end else begin
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (sym_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
`endif
      STOP: begin
        if (sym_end) begin
          // Chain straight into the next frame so queued bytes leave without a gap
          if (count_q != '0) begin
            pop      = 1'b1;
            state_d  = START;
            serial_d = 1'b0;
            shift_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d  = IDLE;
            serial_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    count_d  = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
    wr_ptr_d = push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    ready_d  = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d   = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Storage array is not reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_in_ready = ready_q;
  assign serial_out    = serial_q;
  assign tx_busy       = busy_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered (5 clocks per symbol, 8-entry FIFO).
module tb_uart_tx_buffered;

  localparam int unsigned SYM = 5;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NSYM = 11;
`else
  localparam int unsigned NSYM = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;
  logic [3:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int n;
  logic rdy;

  uart_tx_buffered #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (10_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one full frame starting at the current negedge, one sample per clock
  task automatic check_frame(input logic [7:0] b);
    logic [10:0] syms;
`ifdef UART_TX_PARITY_EN
    syms = {1'b1, ^b, b, 1'b0};
`else
    syms = {1'b1, 1'b1, b, 1'b0};
`endif
    for (int s = 0; s < int'(NSYM); s++) begin
      for (int c = 0; c < int'(SYM); c++) begin
        chk($sformatf("frame_%02h_sym%0d_clk%0d", b, s, c), 32'(serial_out), 32'(syms[s]));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_serial", 32'(serial_out), 32'd1);
    chk("rst_ready",  32'(data_in_ready), 32'd1);
    chk("rst_busy",   32'(tx_busy), 32'd0);
    chk("rst_count",  32'(fifo_count), 32'd0);
    rst = 1'b0;

    // Single byte 0x41 into an idle block
    data_in = 8'h41;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("t1_count_after_push", 32'(fifo_count), 32'd1);
    chk("t1_serial_before_pop", 32'(serial_out), 32'd1);
    chk("t1_busy", 32'(tx_busy), 32'd1);
    @(negedge clk);
    chk("t1_count_after_pop", 32'(fifo_count), 32'd0);
    check_frame(8'h41);
    chk("t1_busy_after_stop", 32'(tx_busy), 32'd0);
    chk("t1_serial_idle", 32'(serial_out), 32'd1);

    // Twelve bytes held on the input; all leave back-to-back in order
    cyc = 0;
    n = 0;
    data_in = 8'h00;
    data_in_valid = 1'b1;
    fork
      begin
        while (n < 12 && cyc < 2000) begin
          rdy = data_in_ready;
          @(negedge clk);
          cyc++;
          if (rdy) begin
            n++;
            data_in = 8'(n);
          end
          if (cyc == 8) begin
            chk("t2_count_c8", 32'(fifo_count), 32'd7);
            chk("t2_ready_c8", 32'(data_in_ready), 32'd1);
          end
          if (cyc == 9) begin
            chk("t2_count_full", 32'(fifo_count), 32'd8);
            chk("t2_ready_full", 32'(data_in_ready), 32'd0);
          end
        end
        data_in_valid = 1'b0;
        chk("t2_all_accepted", 32'(n), 32'd12);
        chk("t2_last_accept_cycle", 32'(cyc), 32'd153);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 12; i++) check_frame(8'(i));
      end
    join
    chk("t2_busy_end", 32'(tx_busy), 32'd0);
    chk("t2_count_end", 32'(fifo_count), 32'd0);

    // Full FIFO while a frame is in DATA; 0xAA waits for the STOP-end pop
    for (int k = 0; k < 9; k++) begin
      data_in = 8'(8'h10 + k);
      data_in_valid = 1'b1;
      @(negedge clk);
    end
    data_in = 8'hAA;
    for (int c = 10; c <= 53; c++) begin
      @(negedge clk);
      if (c == 30 || c == 51) begin
        chk($sformatf("t3_count_c%0d", c), 32'(fifo_count), 32'd8);
        chk($sformatf("t3_ready_c%0d", c), 32'(data_in_ready), 32'd0);
      end
      if (c == 52) begin
        chk("t3_count_after_pop", 32'(fifo_count), 32'd7);
        chk("t3_ready_after_pop", 32'(data_in_ready), 32'd1);
      end
      if (c == 53) begin
        chk("t3_count_after_aa", 32'(fifo_count), 32'd8);
        chk("t3_ready_after_aa", 32'(data_in_ready), 32'd0);
      end
    end
    data_in_valid = 1'b0;
    for (int w = 0; w < 1000 && tx_busy; w++) @(negedge clk);
    chk("t3_drained_busy", 32'(tx_busy), 32'd0);
    chk("t3_drained_count", 32'(fifo_count), 32'd0);

    // Reset mid-frame with three bytes queued; push during reset is dropped
    for (int k = 0; k < 4; k++) begin
      data_in = (k == 0) ? 8'hC3 : 8'(k);
      data_in_valid = 1'b1;
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    chk("t4_queued", 32'(fifo_count), 32'd3);
    for (int c = 5; c <= 24; c++) @(negedge clk);
    chk("t4_serial_mid_frame", 32'(serial_out), 32'd0);
    rst = 1'b1;
    data_in = 8'h55;
    data_in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_in_valid = 1'b0;
    chk("t4_serial_after_rst", 32'(serial_out), 32'd1);
    chk("t4_count_after_rst",  32'(fifo_count), 32'd0);
    chk("t4_busy_after_rst",   32'(tx_busy), 32'd0);
    chk("t4_ready_after_rst",  32'(data_in_ready), 32'd1);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      chk($sformatf("t4_line_high_%0d", c), 32'(serial_out), 32'd1);
    end
    chk("t4_busy_quiet", 32'(tx_busy), 32'd0);
    chk("t4_count_quiet", 32'(fifo_count), 32'd0);

    // Two back-to-back bytes (parity 1 then 0 when parity is enabled)
    data_in = 8'h07;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h03;
    @(negedge clk);
    data_in_valid = 1'b0;
    check_frame(8'h07);
    check_frame(8'h03);
    chk("t5_busy_end", 32'(tx_busy), 32'd0);
    chk("t5_serial_end", 32'(serial_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit buffer entries; must be a power of two and at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_in  input  8  byte to transmit.
REQ-007 SHALL have port data_in_valid  input  1  producer offers data_in.
REQ-008 SHALL have port data_in_ready  output  1  buffer can accept a byte.
REQ-009 SHALL have port serial_out  output  1  UART line, idle high.
REQ-010 SHALL have port tx_busy  output  1  frame in progress or buffer non-empty.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-012 SHALL use SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division); every line symbol is held exactly SYMBOL_EDGE_TIME cycles.
REQ-013 SHALL push data_in into the FIFO on a rising edge where data_in_valid && data_in_ready.
REQ-014 SHALL drive data_in_ready = (fifo_count != FIFO_DEPTH), combinationally from registered state; a same-cycle pop SHALL NOT allow a push when full (no bypass).
REQ-015 SHALL keep fifo_count unchanged on a simultaneous push and pop; wrap pointers modulo FIFO_DEPTH.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 IDLE: when fifo_count > 0, on the next edge SHALL pop the head into the shift register, enter START, and drive serial_out low from that edge.
REQ-018 Minimum latency: a byte pushed into an empty idle block at edge N SHALL pop at edge N+1, with serial_out low from edge N+1.
REQ-019 START: hold low for one symbol, then enter DATA.
REQ-020 DATA: send 8 bits LSB first, one symbol each, then enter PARITY (macro) or STOP.
REQ-021 STOP: hold high for one symbol; at its end SHALL pop and enter START directly if fifo_count > 0 (no idle gap), else enter IDLE.
REQ-022 serial_out SHALL be registered and glitch-free; high in IDLE.
REQ-023 tx_busy SHALL equal (state != IDLE) || (fifo_count != 0).
REQ-024 Frame order on the line SHALL equal push order; no byte dropped or duplicated.
REQ-025 data_in SHALL be ignored when data_in_valid is low or data_in_ready is low; the producer holds data until accepted.

Reset
REQ-026 On rst SHALL go to IDLE, empty the FIFO, and clear the symbol and bit counters, so that serial_out=1, data_in_ready=1, tx_busy=0, fifo_count=0 from the next edge.
REQ-027 A reset mid-frame SHALL abandon the frame, returning serial_out high on the next edge; any push attempted while rst is high SHALL be discarded.

Configuration
REQ-028 Macro UART_TX_PARITY_EN, when defined, SHALL insert an even-parity bit after DATA (XOR of the 8 data bits), giving an 11-symbol frame.
REQ-029 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, giving a 10-symbol 8N1 frame.

Verification (CLOCK_FREQ=50_000_000, BAUD_RATE=10_000_000, SYMBOL_EDGE_TIME=5, FIFO_DEPTH=8)
REQ-030 Push 0x41 after reset -> serial_out low at push edge+1; data symbols 1,0,0,0,0,0,1,0, five cycles each; stop high; frame 50 cycles; tx_busy low right after stop.
REQ-031 Hold data_in_valid with 12 bytes 0x00..0x0B -> data_in_ready drops when fifo_count reaches 8; all 12 bytes leave in order back-to-back, 600 cycles, no idle symbol between frames.
REQ-032 Fill FIFO (8) while a frame is mid-DATA, present 0xAA held -> not accepted until the pop at that frame's STOP end, then accepted the following edge.
REQ-033 Assert rst for one cycle at cycle 23 of a frame with 3 bytes queued -> serial_out=1, fifo_count=0, tx_busy=0 next edge; line stays high.
REQ-034 With UART_TX_PARITY_EN, push 0x07 -> parity symbol 1, then 0x03 -> parity 0; each frame 55 cycles.
